// File: rtl/idp_pkg.sv
// Shared definitions for the instruction-datapath sequencer: state encoding,
// control-word field layout and a small decode helper.
package idp_pkg;

  // Control-word and datapath field widths
  localparam int CW_W       = 20;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  // Bit positions of each field inside the control word
  localparam int CW_D_LSB    = 15;
  localparam int CW_S_LSB    = 10;
  localparam int CW_T_LSB    = 5;
  localparam int CW_OP_LSB   = 1;
  localparam int CW_HALT_BIT = 0;

  // Sequencer states; one instruction walks FETCH -> READ -> EXEC -> WB
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } idp_state_t;

  // Instruction register contents; the halt bit is acted on while fetching
  // and never needs to be kept, so only the datapath fields live here
  typedef struct packed {
    logic [REG_ADDR_W-1:0] d_addr;
    logic [REG_ADDR_W-1:0] s_addr;
    logic [REG_ADDR_W-1:0] t_addr;
    logic [ALU_OP_W-1:0]   alu_op;
  } idp_ir_t;

  // Pull the datapath fields out of a raw control word
  function automatic idp_ir_t decode_cw(input logic [CW_W-1:0] cw);
    idp_ir_t ir;
    ir.d_addr = cw[CW_D_LSB  +: REG_ADDR_W];
    ir.s_addr = cw[CW_S_LSB  +: REG_ADDR_W];
    ir.t_addr = cw[CW_T_LSB  +: REG_ADDR_W];
    ir.alu_op = cw[CW_OP_LSB +: ALU_OP_W];
    return ir;
  endfunction

  // Halt flag of a raw control word
  function automatic logic cw_halt(input logic [CW_W-1:0] cw);
    return cw[CW_HALT_BIT];
  endfunction

  // States in which an instruction is in flight
  function automatic logic state_busy(input idp_state_t s);
    return (s == FETCH) || (s == READ) || (s == EXEC) || (s == WB);
  endfunction

endpackage

// File: rtl/idp_pc_counter.sv
// Program counter for the sequencer: async reset, synchronous clear and an
// increment that wraps back to zero after the last program address.
module idp_pc_counter #(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 2**ADDR_W - 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  // Clear has priority over increment; the wrap point need not be a power of two
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= (pc == LAST) ? '0 : pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/idp_sequencer.sv
// Single-instruction sequencer: fetches a control word at the PC, latches it,
// steps through READ/EXEC/WB and pulses the register-file write enable in WB.
// Runs one instruction per step pulse, or continuously while run mode is on.
module idp_sequencer
  import idp_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 2**ADDR_W - 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  step_pls,
  input  logic                  run_pls,
  input  logic                  clr_pls,
  input  logic [CW_W-1:0]       cw_in,
  output logic [ADDR_W-1:0]     cw_addr,
  output logic [REG_ADDR_W-1:0] S_Addr,
  output logic [REG_ADDR_W-1:0] T_Addr,
  output logic [REG_ADDR_W-1:0] D_Addr,
  output logic [ALU_OP_W-1:0]   ALU_Op,
  output logic                  D_En,
  output logic                  busy,
  output logic                  running,
  output logic                  halted
);

  idp_state_t state, state_nxt;
  idp_ir_t    ir;
  logic       run_flag, run_nxt;
  logic       ir_load;
  logic       pc_clr;
  logic       pc_inc;

  idp_pc_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (pc_clr),
    .inc    (pc_inc),
    .pc     (cw_addr)
  );

  // State, run flag and instruction register; reset aborts any instruction at once
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      run_flag <= 1'b0;
      ir       <= '0;
    end else begin
      state    <= state_nxt;
      run_flag <= run_nxt;
      if (ir_load) begin
        ir <= decode_cw(cw_in);
      end
    end
  end

  // Next state, run-flag update and PC control; in IDLE clear beats run beats step
  always_comb begin
    state_nxt = state;
    run_nxt   = run_flag;
    ir_load   = 1'b0;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;

    if (run_pls && state_busy(state)) begin
      run_nxt = !run_flag;
    end

    case (state)
      IDLE: begin
        if (clr_pls) begin
          pc_clr  = 1'b1;
          run_nxt = 1'b0;
        end else if (run_pls) begin
          run_nxt = !run_flag;
          if (!run_flag) begin
            state_nxt = FETCH;
          end
        end else if (step_pls || run_flag) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        ir_load = 1'b1;
        if (cw_halt(cw_in)) begin
          state_nxt = HALTED;
          run_nxt   = 1'b0;
        end else begin
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        pc_inc    = 1'b1;
        state_nxt = run_nxt ? FETCH : IDLE;
      end
      HALTED: begin
        if (clr_pls) begin
          pc_clr    = 1'b1;
          run_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        run_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath fields come straight from the instruction register
  assign D_Addr = ir.d_addr;
  assign S_Addr = ir.s_addr;
  assign T_Addr = ir.t_addr;
  assign ALU_Op = ir.alu_op;

  // Status flags decode directly from the state so reset clears them immediately
  assign D_En    = (state == WB);
  assign busy    = state_busy(state);
  assign halted  = (state == HALTED);
  assign running = run_flag;

endmodule

// File: doc/idp_sequencer.md
IDP_SEQUENCER -- requirements
Module: idp_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: control-word address width.
REQ-002 Parameter LAST_ADDR, default 2**ADDR_W-1: highest program address; PC wraps after it.
REQ-003 Port clk_in  input  1  clock; all state changes on rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port step_pls  input  1  one-cycle debounced pulse: execute one instruction.
REQ-006 Port run_pls  input  1  one-cycle debounced pulse: toggle run mode.
REQ-007 Port clr_pls  input  1  one-cycle debounced pulse: PC to 0, leave HALTED.
REQ-008 Port cw_in  input  20  control word: [19:15] D_Addr, [14:10] S_Addr, [9:5] T_Addr, [4:1] ALU_Op, [0] halt.
REQ-009 Port cw_addr  output  ADDR_W  current PC, addresses control-word store.
REQ-010 Port S_Addr, T_Addr, D_Addr  output  5 each  register-file addresses from latched word.
REQ-011 Port ALU_Op  output  4  ALU operation from latched word.
REQ-012 Port D_En  output  1  register-file write enable.
REQ-013 Port busy, running, halted  output  1 each  status flags.

Function
REQ-014 FSM states IDLE, FETCH, READ, EXEC, WB, HALTED; one instruction = FETCH->READ->EXEC->WB, one cycle each.
REQ-015 FETCH drives cw_addr=PC; latch cw_in into the instruction register at the end of FETCH.
REQ-016 S_Addr, T_Addr, D_Addr, ALU_Op driven from the instruction register at all times.
REQ-017 D_En=1 only while in WB; 0 in every other state.
REQ-018 busy=1 in FETCH, READ, EXEC, WB; halted=1 only in HALTED; running = run flag.
REQ-019 IDLE + step_pls at edge n: FETCH in cycle n+1, D_En high in cycle n+4, IDLE in cycle n+5.
REQ-020 WB exit: PC increments; PC==LAST_ADDR wraps to 0.
REQ-021 WB exit: next state FETCH if run flag set, else IDLE.
REQ-022 run_pls toggles run flag in any state except HALTED, where it is ignored.
REQ-023 IDLE + run flag set (toggled now or earlier): go to FETCH next cycle.
REQ-024 Clearing run mid-instruction completes the instruction through WB, then IDLE.
REQ-025 Latched halt bit: FETCH->HALTED; skip READ/EXEC/WB, no D_En, PC unchanged, run flag cleared.
REQ-026 step_pls outside IDLE ignored, never queued.
REQ-027 clr_pls honoured only in IDLE or HALTED: PC=0, run flag cleared, next state IDLE; ignored elsewhere.
REQ-028 Same-edge pulses in IDLE: priority clr_pls > run_pls > step_pls; lower ones dropped.

Reset
REQ-029 Reset asserted (async): state IDLE, PC=0, instruction register=0, run flag=0.
REQ-030 Reset outputs: D_En=0, busy=0, running=0, halted=0, all address/op outputs 0, cw_addr=0.
REQ-031 Reset mid-instruction aborts at once; no D_En pulse after reset asserts.

Structure
REQ-032 Package idp_pkg holds state encoding, cw_in field positions, register-address width 5, ALU_Op width 4.
REQ-033 PC in sub-module idp_pc_counter (ADDR_W, LAST_ADDR; async clear, sync clear, increment-with-wrap).

Verification
REQ-034 Reset, cw[PC0]={D=3,S=1,T=2,op=4,halt=0}, step at n -> cw_addr=0 in n+1; D_En=1, D_Addr=3 in n+4 only; cw_addr=1 after.
REQ-035 LAST_ADDR=3, run_pls, no halt words -> cw_addr 0,1,2,3,0 each 4 cycles; D_En every 4th cycle.
REQ-036 Run mode, cw[2].halt=1 -> halted=1, running=0, cw_addr=2, no D_En for word 2; step/run ignored; clr_pls -> IDLE, cw_addr=0.
REQ-037 step_pls during READ, clr_pls during EXEC -> both ignored; one D_En pulse only; PC advances by 1.
REQ-038 IDLE, clr+run+step same edge -> IDLE, PC=0, running=0, no FETCH.
REQ-039 Reset during EXEC -> IDLE, all outputs 0 immediately; no D_En in following 4 cycles.
